// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data memory controller:
//   mem_size_t  - RV32I funct3 load/store size encodings
//   state_t     - controller FSM states
//   LATENCY_MAX - largest supported request-to-response latency
//   size_defined() - whether a funct3 value is a legal load or store size
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int LATENCY_MAX = 4;

   // Stores only have signed encodings; loads also have the unsigned ones.
   function automatic logic size_defined(input logic i_we, input logic [2:0] i_size);
      if (i_we)
         return (i_size == MEM_B) || (i_size == MEM_H) || (i_size == MEM_W);
      return (i_size == MEM_B) || (i_size == MEM_H) || (i_size == MEM_W) ||
             (i_size == MEM_BU) || (i_size == MEM_HU);
   endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// -----------------------------------------------------------------------------
// dmem_byte_lane
// Purely combinational lane steering between a 32-bit memory word and a
// right-aligned load/store operand (little-endian).
// Ports:
//   i_size    - access size (already normalised to a defined encoding)
//   i_addr_lo - byte address bits [1:0]
//   i_wdata   - right-aligned store data
//   i_rword   - memory word currently at the addressed index
//   o_be      - byte enables for the store
//   o_wword   - store data replicated onto every lane (o_be picks the lanes)
//   o_rdata   - extracted and sign/zero-extended load result
// -----------------------------------------------------------------------------
module dmem_byte_lane
   import dmem_pkg::*;
(
   input  logic [2:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be,
   output logic [31:0] o_wword,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
   // Halfword lane is chosen by addr[1] alone; addr[0] never moves a halfword.
   assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

   always_comb begin
      o_be    = 4'b1111;
      o_wword = i_wdata;
      o_rdata = i_rword;
      case (i_size)
         MEM_B, MEM_BU: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wword = {4{i_wdata[7:0]}};
            o_rdata = {{24{(i_size == MEM_B) && w_byte[7]}}, w_byte};
         end
         MEM_H, MEM_HU: begin
            o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wword = {2{i_wdata[15:0]}};
            o_rdata = {{16{(i_size == MEM_H) && w_half[15]}}, w_half};
         end
         default: begin
            o_be    = 4'b1111;
            o_wword = i_wdata;
            o_rdata = i_rword;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Single-outstanding-request RV32I data memory with a valid/ready request and
// response channel and a configurable response latency.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the source holds its payload until then, and a response stays stable
// until rsp_ready is seen.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid / req_ready    - request handshake (ready only in IDLE)
//   req_we, req_addr,
//   req_size, req_wdata      - store/load, byte address, funct3 size, data
//   rsp_valid / rsp_ready    - response handshake
//   rsp_rdata, rsp_err       - extended load data (0 for stores/faults), fault
//   o_dbg_state              - current FSM state, for observation only
//
// Build option: define DMEM_ERR_EN to enable fault detection (misalignment,
// out-of-range word index, undefined size). Without it rsp_err is tied low,
// the word index wraps modulo DEPTH, misaligned low bits are ignored and
// undefined sizes behave as a full word.
// -----------------------------------------------------------------------------
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int    DEPTH     = 1024,
   parameter int    LATENCY   = 1,
   parameter string INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output state_t      o_dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY_MAX + 1);
   localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

   logic [31:0]   r_mem [DEPTH];
   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]   r_rdata;
   logic          r_err;

   logic          w_accept;
   logic          w_fault;
   logic [AW-1:0] w_idx;
   logic [2:0]    w_size_eff;
   logic [31:0]   w_rword;
   logic [3:0]    w_be;
   logic [31:0]   w_wword;
   logic [31:0]   w_lane_rdata;

   assign req_ready   = (r_state == IDLE);
   assign rsp_valid   = (r_state == RESP);
   assign rsp_rdata   = r_rdata;
   assign o_dbg_state = r_state;
   assign w_accept    = req_valid && req_ready && !rst;
   // Taking only the low index bits gives the modulo-DEPTH wrap for free.
   assign w_idx       = req_addr[AW+1:2];
   assign w_rword     = r_mem[w_idx];

`ifdef DMEM_ERR_EN
   logic w_oob;
   assign w_oob      = |req_addr[31:AW+2];
   assign w_size_eff = req_size;
   assign w_fault    = !size_defined(req_we, req_size) ||
                       ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_size == MEM_W) && (req_addr[1:0] != 2'b00)) ||
                       w_oob;
   assign rsp_err    = r_err;
`else
   logic w_unused;
   assign w_size_eff = size_defined(req_we, req_size) ? req_size : MEM_W;
   assign w_fault    = 1'b0;
   assign rsp_err    = 1'b0;
   assign w_unused   = &{1'b0, req_addr[31:AW+2], r_err};
`endif

   dmem_byte_lane u_lane (
      .i_size    (w_size_eff),
      .i_addr_lo (req_addr[1:0]),
      .i_wdata   (req_wdata),
      .i_rword   (w_rword),
      .o_be      (w_be),
      .o_wword   (w_wword),
      .o_rdata   (w_lane_rdata)
   );

   // Memory has no reset: contents survive rst, and a store commits at the
   // accept edge regardless of what later happens to its response.
   always_ff @(posedge clk) begin
      if (w_accept && req_we && !w_fault) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         // Only IDLE accepts, so the response payload is frozen in WAIT/RESP.
         if (w_accept) begin
            r_err   <= w_fault;
            r_rdata <= (w_fault || req_we) ? 32'h0 : w_lane_rdata;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (LATENCY > 1) begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = LAT_M1;
               end else begin
                  w_state_nxt = RESP;
               end
            end
         end
         WAIT: begin
            // Loaded with LATENCY-1: leaves after LATENCY-1 cycles in WAIT.
            if (r_cnt <= CW'(1)) begin
               w_state_nxt = RESP;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Two controller instances share one clock and reset: index 0 uses LATENCY=1,
// DEPTH=1024; index 1 uses LATENCY=3, DEPTH=16. Expected results come from a
// byte-addressed reference memory per instance.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;
   import dmem_pkg::*;

   localparam int D0 = 1024;
   localparam int D1 = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [2:0]  req_size  [2];
   logic [31:0] req_wdata [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];
   state_t      dbg_state [2];

   data_mem_ctrl #(.DEPTH(D0), .LATENCY(1)) u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .o_dbg_state(dbg_state[0])
   );

   data_mem_ctrl #(.DEPTH(D1), .LATENCY(3)) u_dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .o_dbg_state(dbg_state[1])
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   logic [7:0]  mm0 [D0*4];
   logic [7:0]  mm1 [D1*4];
   logic [32:0] exp_q [$];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   function automatic void model(input int sel, input logic we, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata,
                                 output logic [31:0] rd, output logic err);
      int unsigned depth;
      int unsigned n;
      int unsigned ba;
      bit          sgn;
      bit          undef;
      depth = (sel == 1) ? D1 : D0;
      rd    = 32'h0;
      err   = 1'b0;
      n     = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
      sgn   = (size == 3'd0) || (size == 3'd1);
      undef = we ? (size > 3'd2) : ((size == 3'd3) || (size >= 3'd6));
`ifdef DMEM_ERR_EN
      if (undef) err = 1'b1;
      if ((n == 2) && addr[0]) err = 1'b1;
      if ((size == 3'd2) && (addr[1:0] != 2'b00)) err = 1'b1;
      if ((addr >> 2) >= depth) err = 1'b1;
      if (err) return;
      ba = addr;
`else
      if (undef) begin
         n   = 4;
         sgn = 1'b0;
      end
      ba = addr - (addr % n);
      ba = ba % (depth * 4);
`endif
      for (int unsigned k = 0; k < n; k++) begin
         if (we) begin
            if (sel == 1) mm1[ba+k] = wdata[8*k +: 8];
            else          mm0[ba+k] = wdata[8*k +: 8];
         end else begin
            rd[8*k +: 8] = (sel == 1) ? mm1[ba+k] : mm0[ba+k];
         end
      end
      if (!we && sgn) begin
         if ((n == 1) && rd[7])  rd = rd | 32'hFFFF_FF00;
         if ((n == 2) && rd[15]) rd = rd | 32'hFFFF_0000;
      end
   endfunction

   // ---------------- driver ----------------
   // Called just after a falling edge with the instance idle. Returns the
   // response payload, cycles from accept to first rsp_valid, whether the
   // response stayed stable and dropped after consumption, whether req_ready
   // was high before accept and low throughout, and a timeout flag.
   task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata, input int hold,
                      output logic [31:0] rd, output logic err, output int lat,
                      output bit stable, output bit rr_ok, output bit tout);
      stable = 1'b1;
      rr_ok  = 1'b1;
      tout   = 1'b0;
      lat    = 0;
      rd     = 32'h0;
      err    = 1'b0;
      req_valid[sel] = 1'b1;
      req_we[sel]    = we;
      req_addr[sel]  = addr;
      req_size[sel]  = size;
      req_wdata[sel] = wdata;
      if (req_ready[sel] !== 1'b1) rr_ok = 1'b0;
      @(posedge clk);
      #1;
      req_valid[sel] = 1'b0;
      req_we[sel]    = 1'($urandom);
      req_addr[sel]  = $urandom;
      req_size[sel]  = 3'($urandom);
      req_wdata[sel] = $urandom;
      while (1) begin
         @(negedge clk);
         lat++;
         if (req_ready[sel] !== 1'b0) rr_ok = 1'b0;
         if (rsp_valid[sel] === 1'b1) break;
         if (lat >= 16) begin
            tout = 1'b1;
            break;
         end
      end
      if (tout) return;
      rd  = rsp_rdata[sel];
      err = rsp_err[sel];
      repeat (hold) begin
         @(negedge clk);
         if (rsp_valid[sel] !== 1'b1 || rsp_rdata[sel] !== rd || rsp_err[sel] !== err)
            stable = 1'b0;
         if (req_ready[sel] !== 1'b0) rr_ok = 1'b0;
      end
      rsp_ready[sel] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[sel] = 1'b0;
      @(negedge clk);
      if (rsp_valid[sel] !== 1'b0 || req_ready[sel] !== 1'b1) stable = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         n_checks++;
         if (rsp_valid[s] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_valid[%0d]: got %b want 0", s, rsp_valid[s]);
         end
         n_checks++;
         if (rsp_rdata[s] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rsp_rdata[%0d]: got %h want 0", s, rsp_rdata[s]);
         end
         n_checks++;
         if (rsp_err[s] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_err[%0d]: got %b want 0", s, rsp_err[s]);
         end
         n_checks++;
         if (req_ready[s] !== 1'b1 || dbg_state[s] !== IDLE) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: ready %b state %0d want 1/IDLE", s, req_ready[s], dbg_state[s]);
         end
      end
   endtask

   // Fill the windows that later loads read, so no load sees unwritten data.
   task automatic test_prefill();
      logic [31:0] rd, erd;
      logic        err, eerr;
      int          lat;
      bit          stable, rr_ok, tout;
      for (int s = 0; s < 2; s++) begin
         for (int w = 0; w < ((s == 1) ? D1 : 64); w++) begin
            logic [31:0] d;
            d = $urandom;
            model(s, 1'b1, 32'(w * 4), MEM_W, d, erd, eerr);
            txn(s, 1'b1, 32'(w * 4), MEM_W, d, 0, rd, err, lat, stable, rr_ok, tout);
            n_checks++;
            if (tout || err !== eerr || rd !== erd) begin
               n_fail++;
               $display("FAIL prefill[%0d] addr %h: got rd %h err %b to %b want %h/%b",
                        s, w * 4, rd, err, tout, erd, eerr);
            end
         end
      end
   endtask

   task automatic test_basic();
      vec_t        tv [8];
      logic [31:0] rd, erd;
      logic        err, eerr;
      int          lat;
      bit          stable, rr_ok, tout;
      tv = '{
         '{1'b1, 32'h10, MEM_W,  32'hDEADBEEF, 32'h0000_0000, 1'b0},
         '{1'b0, 32'h10, MEM_W,  32'h0,        32'hDEAD_BEEF, 1'b0},
         '{1'b0, 32'h13, MEM_B,  32'h0,        32'hFFFF_FFDE, 1'b0},
         '{1'b0, 32'h13, MEM_BU, 32'h0,        32'h0000_00DE, 1'b0},
         '{1'b0, 32'h10, MEM_H,  32'h0,        32'hFFFF_BEEF, 1'b0},
         '{1'b0, 32'h12, MEM_HU, 32'h0,        32'h0000_DEAD, 1'b0},
         '{1'b1, 32'h11, MEM_B,  32'h55,       32'h0000_0000, 1'b0},
         '{1'b0, 32'h10, MEM_W,  32'h0,        32'hDEAD_55EF, 1'b0}
      };
      foreach (tv[i]) begin
         model(0, tv[i].we, tv[i].addr, tv[i].size, tv[i].wdata, erd, eerr);
         txn(0, tv[i].we, tv[i].addr, tv[i].size, tv[i].wdata, i % 2, rd, err, lat, stable, rr_ok, tout);
         n_checks++;
         if (tout || rd !== tv[i].exp_rd || err !== tv[i].exp_err) begin
            n_fail++;
            $display("FAIL basic[%0d] addr %h size %0d: got %h/%b want %h/%b",
                     i, tv[i].addr, tv[i].size, rd, err, tv[i].exp_rd, tv[i].exp_err);
         end
         n_checks++;
         if (lat != 1 || !stable || !rr_ok) begin
            n_fail++;
            $display("FAIL basic_timing[%0d]: lat %0d stable %b ready_ok %b want 1/1/1", i, lat, stable, rr_ok);
         end
      end
   endtask

   task automatic test_faults();
      vec_t        tv [6];
      logic [31:0] rd, erd;
      logic        err, eerr;
      int          lat;
      bit          stable, rr_ok, tout;
`ifdef DMEM_ERR_EN
      tv = '{
         '{1'b1, 32'h12,      MEM_W,  32'h1234_5678, 32'h0,         1'b1},
         '{1'b0, 32'h10,      MEM_W,  32'h0,         32'hDEAD_55EF, 1'b0},
         '{1'b0, 32'(D0 * 4), MEM_W,  32'h0,         32'h0,         1'b1},
         '{1'b0, 32'h11,      MEM_H,  32'h0,         32'h0,         1'b1},
         '{1'b1, 32'h10,      3'b100, 32'h0000_0011, 32'h0,         1'b1},
         '{1'b0, 32'h10,      3'b011, 32'h0,         32'h0,         1'b1}
      };
`else
      tv = '{
         '{1'b1, 32'h12,             MEM_W,  32'h1234_5678, 32'h0,         1'b0},
         '{1'b0, 32'h10,             MEM_W,  32'h0,         32'h1234_5678, 1'b0},
         '{1'b0, 32'(D0 * 4 + 'h10), MEM_W,  32'h0,         32'h1234_5678, 1'b0},
         '{1'b0, 32'h13,             MEM_H,  32'h0,         32'h0000_1234, 1'b0},
         '{1'b1, 32'h11,             3'b100, 32'hCAFE_F00D, 32'h0,         1'b0},
         '{1'b0, 32'h12,             3'b011, 32'h0,         32'hCAFE_F00D, 1'b0}
      };
`endif
      foreach (tv[i]) begin
         model(0, tv[i].we, tv[i].addr, tv[i].size, tv[i].wdata, erd, eerr);
         txn(0, tv[i].we, tv[i].addr, tv[i].size, tv[i].wdata, 0, rd, err, lat, stable, rr_ok, tout);
         n_checks++;
         if (tout || rd !== tv[i].exp_rd || err !== tv[i].exp_err || lat != 1) begin
            n_fail++;
            $display("FAIL fault[%0d] addr %h size %0d: got %h/%b lat %0d want %h/%b lat 1",
                     i, tv[i].addr, tv[i].size, rd, err, lat, tv[i].exp_rd, tv[i].exp_err);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, addr, d;
      logic        err, eerr, we;
      logic [2:0]  size;
      logic [32:0] exp;
      int          lat, sel, depth;
      bit          stable, rr_ok, tout;
      for (int i = 0; i < 300; i++) begin
         sel   = $urandom_range(0, 1);
         depth = (sel == 1) ? D1 : D0;
         we    = 1'($urandom_range(0, 1));
         size  = 3'($urandom_range(0, 7));
         d     = $urandom;
         addr  = 32'($urandom_range(0, (sel == 1) ? 63 : 255));
         if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3) * depth * 4);
         model(sel, we, addr, size, d, erd, eerr);
         exp_q.push_back({eerr, erd});
         txn(sel, we, addr, size, d, $urandom_range(0, 2), rd, err, lat, stable, rr_ok, tout);
         exp = exp_q.pop_front();
         n_checks++;
         if (tout || {err, rd} !== exp) begin
            n_fail++;
            $display("FAIL random[%0d] inst %0d we %b addr %h size %0d: got %b/%h want %b/%h",
                     i, sel, we, addr, size, err, rd, exp[32], exp[31:0]);
         end
         n_checks++;
         if (lat != ((sel == 1) ? 3 : 1) || !stable || !rr_ok) begin
            n_fail++;
            $display("FAIL random_timing[%0d] inst %0d: lat %0d stable %b ready_ok %b", i, sel, lat, stable, rr_ok);
         end
      end
   endtask

   task automatic test_latency();
      logic [31:0] rd, erd;
      logic        err, eerr;
      int          lat;
      bit          stable, rr_ok, tout;
      model(1, 1'b0, 32'h4, MEM_W, 32'h0, erd, eerr);
      txn(1, 1'b0, 32'h4, MEM_W, 32'h0, 2, rd, err, lat, stable, rr_ok, tout);
      n_checks++;
      if (tout || lat != 3) begin
         n_fail++;
         $display("FAIL latency3: got lat %0d timeout %b want 3", lat, tout);
      end
      n_checks++;
      if (!stable || !rr_ok) begin
         n_fail++;
         $display("FAIL latency3_hold: stable %b ready_ok %b want 1/1", stable, rr_ok);
      end
      n_checks++;
      if (rd !== erd || err !== eerr) begin
         n_fail++;
         $display("FAIL latency3_data: got %h/%b want %h/%b", rd, err, erd, eerr);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, erd;
      logic        err, eerr;
      int          lat;
      bit          stable, rr_ok, tout;
      bit          quiet;
      model(1, 1'b1, 32'h8, MEM_W, 32'hA5A5_1234, erd, eerr);
      txn(1, 1'b1, 32'h8, MEM_W, 32'hA5A5_1234, 0, rd, err, lat, stable, rr_ok, tout);
      // Pass 0: store interrupted in WAIT; pass 1: load interrupted in WAIT.
      for (int p = 0; p < 2; p++) begin
         req_valid[1] = 1'b1;
         req_we[1]    = (p == 0);
         req_addr[1]  = (p == 0) ? 32'hC : 32'h8;
         req_size[1]  = MEM_W;
         req_wdata[1] = 32'hCAFE_F00D;
         if (p == 0) model(1, 1'b1, 32'hC, MEM_W, 32'hCAFE_F00D, erd, eerr);
         @(posedge clk);
         #1 req_valid[1] = 1'b0;
         @(negedge clk);
         n_checks++;
         if (dbg_state[1] !== WAIT) begin
            n_fail++;
            $display("FAIL rstmid_wait[%0d]: state %0d want WAIT", p, dbg_state[1]);
         end
         rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         n_checks++;
         if (dbg_state[1] !== IDLE || rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1 || rsp_rdata[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_idle[%0d]: state %0d valid %b ready %b rdata %h want IDLE/0/1/0",
                     p, dbg_state[1], rsp_valid[1], req_ready[1], rsp_rdata[1]);
         end
         quiet = 1'b1;
         repeat (4) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) quiet = 1'b0;
         end
         n_checks++;
         if (!quiet) begin
            n_fail++;
            $display("FAIL rstmid_dropped[%0d]: rsp_valid rose after reset, want 0", p);
         end
      end
      txn(1, 1'b0, 32'h8, MEM_W, 32'h0, 0, rd, err, lat, stable, rr_ok, tout);
      n_checks++;
      if (tout || rd !== 32'hA5A5_1234) begin
         n_fail++;
         $display("FAIL rstmid_keep8: got %h want a5a51234", rd);
      end
      txn(1, 1'b0, 32'hC, MEM_W, 32'h0, 0, rd, err, lat, stable, rr_ok, tout);
      n_checks++;
      if (tout || rd !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL rstmid_keepC: got %h want cafef00d", rd);
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         req_valid[s] = 1'b0;
         req_we[s]    = 1'b0;
         req_addr[s]  = 32'h0;
         req_size[s]  = 3'b0;
         req_wdata[s] = 32'h0;
         rsp_ready[s] = 1'b0;
      end
      test_reset();
      test_prefill();
      test_basic();
      test_faults();
      test_latency();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
